hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller; companion to the EX-stage forwarding unit.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/sat_counter.sv | 18 +
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, defaults and load-use detection for the stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam int          MD_LATENCY_DEF = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic        CTRL_BUBBLE    = 1'b1;

    // $zero never carries a real dependency, so a load to r0 cannot cause a hazard.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc && q != {W{1'b1}})
            q <= q + W'(1);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and fixed-latency mul/div freeze sequencing,
// with a saturating count of front-end stall cycles.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_Rt,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic              IF_ID_UsesRt,
    input  logic              branch_taken,
    input  logic              md_start,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              ID_EX_Write,
    output logic              ID_EX_Bubble,
    output logic              EX_MEM_Bubble,
    output logic              IF_ID_Flush,
    output logic              md_busy,
    output logic              md_done,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LATENCY - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_lu;
    logic             w_last;
    logic             w_run;
    logic             w_wait;
    logic             w_flush;
    logic             w_stall;

    assign w_lu   = load_use(ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
    assign w_last = r_state == MD_WAIT && r_md_cnt == CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_md_cnt;
        if (r_state == MD_WAIT) begin
            w_next_cnt   = r_md_cnt - CNT_W'(1);
            w_next_state = w_last ? RUN : MD_WAIT;
        end else if (md_start) begin
            w_next_state = MD_WAIT;
            w_next_cnt   = MD_INIT;
        end
    end

    // Branch wins over load-use: the dependent ID instruction is being flushed anyway.
    always_comb begin
        w_run         = !rst && r_state == RUN;
        w_wait        = !rst && r_state == MD_WAIT;
        w_flush       = w_run && branch_taken;
        w_stall       = w_run && w_lu && !branch_taken;
        PC_Write      = w_run && !w_stall;
        IF_ID_Write   = w_run && !w_stall;
        ID_EX_Write   = w_run;
        ID_EX_Bubble  = rst || w_flush || w_stall ? CTRL_BUBBLE : 1'b0;
        EX_MEM_Bubble = rst || (w_wait && !w_last) ? CTRL_BUBBLE : 1'b0;
        IF_ID_Flush   = w_flush;
        md_busy       = w_wait;
        md_done       = w_wait && w_last;
    end

    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!PC_Write),
        .q   (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed plus random stimulus against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MDL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr = 1'b0, uses = 1'b0, bt = 1'b0, mds = 1'b0;
    logic [4:0]  rt_ex = '0, rs = '0, rt_id = '0;
    logic        pc_w, ifid_w, idex_w, idex_b, exmem_b, ifid_f, busy, done;
    logic [15:0] stall_cycles;
    logic        sc_rst = 1'b1, sc_inc = 1'b0;
    logic [3:0]  sc_q;

    int n_assert = 0;
    int n_fail   = 0;
    int md_left  = 0;
    int stalls   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(MDL), .CNT_W(6), .STAT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_EX_MemRead (mr),
        .ID_EX_Rt      (rt_ex),
        .IF_ID_Rs      (rs),
        .IF_ID_Rt      (rt_id),
        .IF_ID_UsesRt  (uses),
        .branch_taken  (bt),
        .md_start      (mds),
        .PC_Write      (pc_w),
        .IF_ID_Write   (ifid_w),
        .ID_EX_Write   (idex_w),
        .ID_EX_Bubble  (idex_b),
        .EX_MEM_Bubble (exmem_b),
        .IF_ID_Flush   (ifid_f),
        .md_busy       (busy),
        .md_done       (done),
        .stall_cycles  (stall_cycles)
    );

    sat_counter #(.W(4)) u_sc (.clk(clk), .rst(sc_rst), .inc(sc_inc), .q(sc_q));

    // Expected {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush, md_busy, md_done}
    function automatic logic [7:0] model_out();
        logic lu;
        if (rst) return 8'b000_11_000;
        if (md_left > 0) return {3'b000, 1'b0, md_left != 1, 1'b0, 1'b1, md_left == 1};
        lu = mr && rt_ex != 0 && (rt_ex == rs || (uses && rt_ex == rt_id));
        if (bt) return 8'b111_10_100;
        if (lu) return 8'b001_10_000;
        return 8'b111_00_000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = model_out();
        check(tag, {24'd0, pc_w, ifid_w, idex_w, idex_b, exmem_b, ifid_f, busy, done}, {24'd0, e});
        check({tag, "_cnt"}, {16'd0, stall_cycles}, stalls);
        @(posedge clk);
        if (!rst) begin
            if (!e[7] && stalls < 65535) stalls++;
            if (md_left > 0) md_left--;
            else if (mds) md_left = MDL - 1;
        end
        #1;
    endtask

    task automatic set_in(input logic m, input logic [4:0] r_ex, input logic [4:0] r_s,
                          input logic [4:0] r_t, input logic u, input logic b, input logic s);
        mr = m; rt_ex = r_ex; rs = r_s; rt_id = r_t; uses = u; bt = b; mds = s;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        md_left = 0;
        stalls = 0;
    endtask

    initial begin
        set_in(1, 8, 8, 0, 0, 0, 0);
        step("rst_hold0");
        step("rst_hold1");
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        step("run_first");
        step("run_idle");
        assert_reset();
        #2;
        check("rst_async_pc", {31'd0, pc_w}, 0);
        step("rst_mid");
        rst = 1'b0;
        step("rst_release");
        set_in(1, 8, 8, 0, 0, 0, 0);
        step("lu_rs");
        set_in(0, 0, 0, 0, 0, 0, 0);
        step("lu_after");
        check("lu_one_stall", {16'd0, stall_cycles}, 1);
        set_in(1, 0, 0, 0, 1, 0, 0);
        step("lu_r0");
        set_in(1, 8, 1, 8, 0, 0, 0);
        step("lu_rt_unused");
        set_in(1, 8, 1, 8, 1, 0, 0);
        step("lu_rt_used");
        set_in(1, 8, 8, 8, 1, 1, 0);
        step("bt_over_lu");
        set_in(0, 0, 0, 0, 0, 0, 1);
        step("md_start");
        mds = 1'b0;
        for (int i = 0; i < MDL; i++) step("md_wait");
        set_in(0, 0, 0, 0, 0, 1, 1);
        step("md_and_bt");
        set_in(0, 0, 0, 0, 0, 0, 0);
        step("md_w1");
        assert_reset();
        #2;
        check("rst_md_done", {31'd0, done}, 0);
        step("rst_in_md");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("after_md_rst");
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                   5'($urandom_range(3, 0)), $urandom_range(1, 0) == 1,
                   $urandom_range(5, 0) == 0, $urandom_range(9, 0) == 0);
            step("rand");
        end
        sc_rst = 1'b0;
        sc_inc = 1'b1;
        for (int i = 0; i < 7; i++) @(posedge clk);
        #1;
        check("sat_mid", {28'd0, sc_q}, 7);
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1;
        check("sat_max", {28'd0, sc_q}, 15);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("sat_hold", {28'd0, sc_q}, 15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
